cvs_edge_counter: RTL and testbench

Downstream measurement stage for the five `simple_fpga_cvs` outputs. It sits in the `clock` domain. Each `sig_in` bit is treated as asynchronous: it is synchronised, and its rising edges are counted over a fixed gate window of `GATE_CYCLES` clocks. At the end of every window, per-channel counts are published through a valid/ready result interface, so software or a checker can confirm each channel's toggle rate.

---
 rtl/cvs_edge_counter_pkg.sv | 21 ++
 rtl/cvs_edge_counter_sync.sv | 47 ++++
 rtl/cvs_edge_counter.sv | 197 +++++++++++++++++++
 tb/tb_cvs_edge_counter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cvs_edge_counter_pkg.sv
// -----------------------------------------------------------------------------
// cvs_pkg
// Shared types and constants for the cvs edge-counter measurement stage.
//   cvs_cnt_state_t : window state machine encoding (IDLE / COUNT)
//   cvs_seq_t       : 8-bit wrapping result sequence number
//   CVS_NUM_CH      : default number of monitored channels
//   CVS_DEFAULT_GATE: default gate window length in clock cycles
// -----------------------------------------------------------------------------
package cvs_pkg;

  localparam int CVS_NUM_CH       = 5;
  localparam int CVS_DEFAULT_GATE = 1000;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } cvs_cnt_state_t;

  typedef logic [7:0] cvs_seq_t;

endpackage

// File: rtl/cvs_edge_counter_sync.sv
// -----------------------------------------------------------------------------
// cvs_edge_sync
// Single-channel synchroniser plus edge detector. The asynchronous input d
// passes through SYNC_STAGES flops, then one history flop; edge_pulse is a
// one-cycle flag derived only from flopped values.
// Build option: CVS_EDGE_COUNTER_BOTH_EDGES_EN
//   undefined : edge_pulse flags rising edges only
//   defined   : edge_pulse flags rising and falling edges
// Ports:
//   clock      in  system clock, rising edge
//   reset_n    in  asynchronous active-low reset
//   d          in  asynchronous input bit
//   edge_pulse out one-cycle edge flag in the clock domain
// -----------------------------------------------------------------------------
module cvs_edge_sync import cvs_pkg::*; #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;

  // Synchroniser chain and history flop; sync_r[0] is the metastable capture stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      hist_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Edge flag: compare the settled stage against the previous settled value.
  always_comb begin
`ifdef CVS_EDGE_COUNTER_BOTH_EDGES_EN
    edge_pulse = sync_r[SYNC_STAGES-1] ^ hist_r;
`else
    edge_pulse = sync_r[SYNC_STAGES-1] & ~hist_r;
`endif
  end

endmodule

// File: rtl/cvs_edge_counter.sv
// -----------------------------------------------------------------------------
// cvs_edge_counter
// Counts edges on NUM_CH asynchronous inputs over back-to-back gate windows of
// GATE_CYCLES clocks and publishes per-channel counts through a valid/ready
// result interface at the end of every window.
// Build option: CVS_EDGE_COUNTER_BOTH_EDGES_EN (count both edges instead of
// rising edges only; handled inside cvs_edge_sync, port list unchanged).
// Ports:
//   clock          in  system clock, rising edge
//   reset_n        in  asynchronous active-low reset (release is expected to be
//                      synchronous to clock)
//   enable         in  high = run back-to-back gate windows; low aborts a window
//   sig_in         in  NUM_CH monitored signals, asynchronous to clock
//   result_valid   out a result is held for the consumer
//   result_ready   in  consumer accepts when high together with result_valid
//   result_count   out channel k count in bits [k*COUNT_W +: COUNT_W]
//   result_sat     out per-channel saturation flag for the published window
//   result_overrun out this result overwrote an unaccepted one
//   result_seq     out window sequence number, wraps 255 -> 0
// -----------------------------------------------------------------------------
module cvs_edge_counter import cvs_pkg::*; #(
  parameter int NUM_CH      = CVS_NUM_CH,
  parameter int GATE_CYCLES = CVS_DEFAULT_GATE,
  parameter int COUNT_W     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         sig_in,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [NUM_CH*COUNT_W-1:0] result_count,
  output logic [NUM_CH-1:0]         result_sat,
  output logic                      result_overrun,
  output logic [7:0]                result_seq
);

  localparam int                 GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0]  GATE_ZERO = GATE_W'(1'b0);
  localparam logic [GATE_W-1:0]  GATE_ONE  = GATE_W'(1'b1);
  localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_ZERO  = COUNT_W'(1'b0);
  localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1'b1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};

  // Saturating increment: a counter parks at CNT_MAX instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] val,
                                                 input logic               inc);
    logic [COUNT_W-1:0] res;
    if (inc && (val != CNT_MAX)) begin
      res = val + CNT_ONE;
    end else begin
      res = val;
    end
    return res;
  endfunction

  logic [NUM_CH-1:0]         edge_s;
  cvs_cnt_state_t            state_r;
  cvs_cnt_state_t            state_nx_s;
  logic [GATE_W-1:0]         gate_r;
  logic [GATE_W-1:0]         gate_nx_s;
  logic                      load_s;
  logic                      cnt_clr_s;
  logic                      accept_s;
  logic [COUNT_W-1:0]        cnt_r     [NUM_CH];
  logic [COUNT_W-1:0]        cnt_inc_s [NUM_CH];
  logic [NUM_CH*COUNT_W-1:0] cnt_pack_s;
  logic [NUM_CH-1:0]         cnt_sat_s;

  logic                      res_valid_r;
  logic [NUM_CH*COUNT_W-1:0] res_count_r;
  logic [NUM_CH-1:0]         res_sat_r;
  logic                      res_overrun_r;
  cvs_seq_t                  res_seq_r;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      cvs_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
        .clock      (clock),
        .reset_n    (reset_n),
        .d          (sig_in[gi]),
        .edge_pulse (edge_s[gi])
      );
    end
  endgenerate

  // Count-plus-this-cycle's-edge per channel; also the value published at window end.
  always_comb begin
    cnt_pack_s = {(NUM_CH*COUNT_W){1'b0}};
    cnt_sat_s  = {NUM_CH{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_inc_s[k]                       = sat_inc(cnt_r[k], edge_s[k]);
      cnt_pack_s[k*COUNT_W +: COUNT_W]   = cnt_inc_s[k];
      cnt_sat_s[k]                       = (cnt_inc_s[k] == CNT_MAX);
    end
  end

  // Window state machine: next state, gate counter, publish and clear controls.
  always_comb begin
    state_nx_s = state_r;
    gate_nx_s  = gate_r;
    load_s     = 1'b0;
    cnt_clr_s  = 1'b1;
    case (state_r)
      IDLE: begin
        gate_nx_s = GATE_ZERO;
        if (enable) begin
          state_nx_s = COUNT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      COUNT: begin
        if (!enable) begin
          // Abort: drop the partial window, nothing is published.
          state_nx_s = IDLE;
          gate_nx_s  = GATE_ZERO;
        end else if (gate_r == GATE_LAST) begin
          // Terminal cycle: publish and restart with no dead cycle.
          load_s    = 1'b1;
          gate_nx_s = GATE_ZERO;
        end else begin
          gate_nx_s = gate_r + GATE_ONE;
          cnt_clr_s = 1'b0;
        end
      end
      default: begin
        state_nx_s = IDLE;
        gate_nx_s  = GATE_ZERO;
      end
    endcase
  end

  // State and gate counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      gate_r  <= GATE_ZERO;
    end else begin
      state_r <= state_nx_s;
      gate_r  <= gate_nx_s;
    end
  end

  // Per-channel edge counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_r[k] <= CNT_ZERO;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (cnt_clr_s) begin
          cnt_r[k] <= CNT_ZERO;
        end else begin
          cnt_r[k] <= cnt_inc_s[k];
        end
      end
    end
  end

  assign accept_s = res_valid_r & result_ready;

  // Result holding register; a window end wins over acceptance, and overrun
  // marks a load that replaced a result nobody took.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      res_valid_r   <= 1'b0;
      res_count_r   <= {(NUM_CH*COUNT_W){1'b0}};
      res_sat_r     <= {NUM_CH{1'b0}};
      res_overrun_r <= 1'b0;
      res_seq_r     <= 8'd0;
    end else if (load_s) begin
      res_valid_r   <= 1'b1;
      res_count_r   <= cnt_pack_s;
      res_sat_r     <= cnt_sat_s;
      res_overrun_r <= res_valid_r & ~result_ready;
      res_seq_r     <= res_seq_r + 8'd1;
    end else if (accept_s) begin
      res_valid_r   <= 1'b0;
    end else begin
      res_valid_r   <= res_valid_r;
    end
  end

  assign result_valid   = res_valid_r;
  assign result_count   = res_count_r;
  assign result_sat     = res_sat_r;
  assign result_overrun = res_overrun_r;
  assign result_seq     = res_seq_r;

endmodule

// File: tb/tb_cvs_edge_counter.sv
// -----------------------------------------------------------------------------
// tb_cvs_edge_counter
// Directed bench with a scoreboard queue. DUT: GATE_CYCLES=100, COUNT_W=5.
// Stimulus: ch0 square wave period 10, ch2 high from reset release, ch3
// toggling every cycle (saturates), ch1/ch4 low.
// -----------------------------------------------------------------------------
module tb_cvs_edge_counter;

  localparam int NCH  = 5;
  localparam int GATE = 100;
  localparam int CW   = 5;
`ifdef CVS_EDGE_COUNTER_BOTH_EDGES_EN
  localparam int CH0_N = 20;
`else
  localparam int CH0_N = 10;
`endif

  logic              clock = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [NCH-1:0]    sig_in;
  logic              result_valid;
  logic              result_ready;
  logic [NCH*CW-1:0] result_count;
  logic [NCH-1:0]    result_sat;
  logic              result_overrun;
  logic [7:0]        result_seq;

  always #5 clock = ~clock;

  cvs_edge_counter #(
    .NUM_CH(NCH), .GATE_CYCLES(GATE), .COUNT_W(CW), .SYNC_STAGES(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_count(result_count), .result_sat(result_sat),
    .result_overrun(result_overrun), .result_seq(result_seq)
  );

  typedef struct {
    logic [NCH*CW-1:0] cnt;
    logic [NCH-1:0]    sat;
    logic              ov;
    logic [7:0]        seq;
    int                gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc_cnt = 0;
  int   last_xfer = 0;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  // Expected result: ch1/ch4 idle, ch3 saturated at 31.
  task automatic push_exp(input int c0, input int c2, input int seq, input logic ov, input int gap);
    exp_t e;
    e.cnt = {5'd0, 5'd31, 5'(c2), 5'd0, 5'(c0)};
    e.sat = 5'b01000;
    e.ov  = ov;
    e.seq = 8'(seq);
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic wait_drain(input string name, input int lim);
    int i = 0;
    while (exp_q.size() != 0 && i < lim) begin
      @(negedge clock);
      i++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d results still outstanding after %0d cycles, want 0", name, exp_q.size(), lim);
      exp_q.delete();
    end
  endtask

  task automatic wait_seq(input logic [7:0] s, input int lim);
    int i = 0;
    while (!(result_valid && result_seq == s) && i < lim) begin
      @(negedge clock);
      i++;
    end
    n_vec++;
    if (!(result_valid && result_seq == s)) begin
      n_bad++;
      $display("FAIL wait_seq: got valid=%b seq=%0d, want valid=1 seq=%0d", result_valid, result_seq, s);
    end
  endtask

  task automatic wait_valid(input int lim);
    int i = 0;
    while (!result_valid && i < lim) begin
      @(negedge clock);
      i++;
    end
    n_vec++;
    if (!result_valid) begin
      n_bad++;
      $display("FAIL wait_valid: got valid=0 after %0d cycles, want 1", lim);
    end
  endtask

  // Input generator: g counts negedges since reset release.
  initial begin : gen
    int g;
    g = 0;
    sig_in = 5'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) g = 0;
      else g = g + 1;
      sig_in[0] = (g >= 1) && ((g / 5) % 2 == 0);
      sig_in[1] = 1'b0;
      sig_in[2] = (g >= 1);
      sig_in[3] = (g >= 1) && (g % 2 == 1);
      sig_in[4] = 1'b0;
    end
  end

  // Monitor: compares every accepted result against the scoreboard head.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (result_valid && result_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_result: got seq=%0d cnt=%h, want no result", result_seq, result_count);
        end else begin
          e = exp_q.pop_front();
          if ({result_count, result_sat, result_overrun, result_seq} !== {e.cnt, e.sat, e.ov, e.seq}) begin
            n_bad++;
            $display("FAIL result seq%0d: got cnt=%h sat=%b ov=%b seq=%0d, want cnt=%h sat=%b ov=%b seq=%0d",
                     e.seq, result_count, result_sat, result_overrun, result_seq, e.cnt, e.sat, e.ov, e.seq);
          end
          if (e.gap != 0) begin
            n_vec++;
            if (cyc_cnt - last_xfer != e.gap) begin
              n_bad++;
              $display("FAIL gap seq%0d: got %0d cycles, want %0d", e.seq, cyc_cnt - last_xfer, e.gap);
            end
          end
        end
        last_xfer = cyc_cnt;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    reset_n      = 1'b0;
    enable       = 1'b0;
    result_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", 64'(result_valid), 64'd0);
    chk("rst_count", 64'(result_count), 64'd0);
    chk("rst_sat", 64'(result_sat), 64'd0);
    chk("rst_overrun", 64'(result_overrun), 64'd0);
    chk("rst_seq", 64'(result_seq), 64'd0);

    // Back-to-back windows, ready held high; ch2's initial rise only in window 1.
    push_exp(CH0_N, 1, 1, 1'b0, 0);
    push_exp(CH0_N, 0, 2, 1'b0, 100);
    push_exp(CH0_N, 0, 3, 1'b0, 100);
    push_exp(CH0_N, 0, 4, 1'b0, 100);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    enable  = 1'b1;
    wait_drain("windows_1_4", 600);

    // Two window ends with ready low: seq5 is overwritten by seq6.
    @(negedge clock);
    result_ready = 1'b0;
    push_exp(CH0_N, 0, 6, 1'b1, 0);
    wait_seq(8'd6, 400);
    result_ready = 1'b1;
    @(negedge clock);
    chk("valid_after_xfer", 64'(result_valid), 64'd0);
    chk("overrun_q_empty", 64'(exp_q.size()), 64'd0);
    result_ready = 1'b0;

    // Accept the pending result on the same edge the next window ends.
    push_exp(CH0_N, 0, 7, 1'b0, 0);
    push_exp(CH0_N, 0, 8, 1'b0, 1);
    wait_valid(200);
    repeat (99) @(negedge clock);
    result_ready = 1'b1;
    wait_drain("simultaneous", 20);

    // Abort mid-window: no result, next full window is correct.
    repeat (49) @(negedge clock);
    enable = 1'b0;
    repeat (10) @(negedge clock);
    enable = 1'b1;
    push_exp(CH0_N, 0, 9, 1'b0, 0);
    push_exp(CH0_N, 0, 10, 1'b0, 100);
    wait_drain("abort_recover", 400);

    // Reset mid-window clears outputs at once.
    repeat (30) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(result_valid), 64'd0);
    chk("midrst_count", 64'(result_count), 64'd0);
    chk("midrst_sat", 64'(result_sat), 64'd0);
    chk("midrst_overrun", 64'(result_overrun), 64'd0);
    chk("midrst_seq", 64'(result_seq), 64'd0);
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    push_exp(CH0_N, 1, 1, 1'b0, 0);
    wait_drain("after_reset", 300);
    repeat (5) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
